fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core; sits directly upstream of the IF/ID pipeline register and feeds its instr_in_1/pc_4_in_1 inputs.
- Owns the PC and runs the instruction-memory request handshake.
- Holds fetched words in a small in-order buffer so fetch continues while decode stalls.
- Handles branch/jump redirects, including a redirect that arrives while a miss is outstanding, and stops fetching at HALT.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
BUF_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
iREN  out  1  instruction read request
iaddr  out  32  request address (word aligned)
ihit  in  1  memory returns iload for the current request this cycle
iload  in  32  fetched instruction word
redirect  in  1  branch/jump/JR taken; flush and refetch
redirect_pc  in  32  target address
ready_in  in  1  IF/ID accepts the head entry (not stalled)
valid_out  out  1  head entry valid
instr_out  out  32  head instruction
pc_4_out  out  32  head PC+4
halted  out  1  HALT fetched; fetching stopped

Behaviour:
- Reset (RST high at a rising edge):
  - pc<=PC_INIT, state<=RUN, buffer count/head/tail<=0, pending_pc<=0.
  - Outputs after reset: iREN=0 only if the buffer is full (never true after reset, so iREN=1), iaddr=PC_INIT, valid_out=0, halted=0.
  - Reset in any state, including mid-miss, abandons the request; no word is enqueued.
- States: RUN, WAIT, SQUASH, HALTED.
- RUN:
  - iREN = (count < BUF_DEPTH); iaddr=pc.
  - iREN & ihit: enqueue {iload, pc+4}; pc<=pc+4.
  - iREN & !ihit: go to WAIT.
- WAIT:
  - iREN=1; iaddr is held at pc until ihit.
  - On ihit: enqueue, pc<=pc+4, go to RUN.
  - Space is guaranteed, because only fetch enqueues.
- Redirect (highest priority):
  - Buffer is flushed (count, head, tail <= 0). Any dequeue in the same cycle is ignored, and valid_out is forced to 0 that cycle.
  - RUN with no request outstanding, or with ihit this cycle: discard the returned word, pc<=redirect_pc, stay in RUN.
  - WAIT with ihit: discard, pc<=redirect_pc, go to RUN.
  - RUN or WAIT with iREN & !ihit: pending_pc<=redirect_pc, go to SQUASH. The request address must not change before ihit.
  - SQUASH: a new redirect overwrites pending_pc.
  - HALTED: pc<=redirect_pc, halted<=0, go to RUN.
- SQUASH:
  - iREN=1; iaddr=pc (the old address).
  - On ihit: discard iload, pc<=pending_pc, go to RUN.
  - valid_out stays 0 (buffer is empty).
- HALT detection:
  - An enqueued word with opcode bits[31:26]==HALT (6'b111111) is still enqueued.
  - Next state is HALTED, pc is not advanced, and iREN=0 from the next cycle.
  - halted=1 while in HALTED.
- Buffer:
  - Circular; head/tail are $clog2(BUF_DEPTH) bits and wrap; count is $clog2(BUF_DEPTH+1) bits.
  - Dequeue when valid_out & ready_in.
  - Enqueue and dequeue in the same cycle are both applied.
  - No bypass: latency from ihit to valid_out is 1 cycle.
  - Outputs always reflect the head entry; instr_out/pc_4_out are don't-care when valid_out=0.
- Arithmetic: pc+4 is 32-bit and wraps mod 2^32; redirect_pc[1:0] is ignored (forced to 00).

Decomposition:
- cpu_types_pkg gets:
  - word_t
  - HALT opcode constant
  - fetch_state_t enum {RUN, WAIT, SQUASH, HALTED}
  - fetch_entry_t struct {word_t instr; word_t pc_4}
- Sub-module fetch_buffer: a parameterised BUF_DEPTH FIFO of fetch_entry_t with enq, deq, flush, full, empty and head outputs, synchronous active-high reset on CLK/RST.

Test Plan:
1. Reset, then ihit=1 and ready_in=1 throughout -> iaddr 0,4,8 on consecutive cycles; first valid_out on the second cycle after reset release with pc_4_out=4, then 8, 12.
2. ihit=0 for 3 cycles at iaddr=8 -> iaddr held at 8 and iREN=1 for 3 cycles, nothing enqueued; on ihit, instr enqueued with pc_4_out=12 and next iaddr=12.
3. Miss at 0x10, redirect to 0x100 in the same cycle -> state SQUASH, iaddr stays 0x10 until ihit, word discarded, next iaddr=0x100, valid_out=0 until the 0x100 word (pc_4_out=0x104).
4. ready_in=0 with BUF_DEPTH=2 -> two entries buffered, iREN drops, pc held; ready_in=1 -> entries drain in order and fetch resumes.
5. iload=0xFFFF_FFFF at 0x20 -> entry enqueued with pc_4_out=0x24, halted=1 next cycle, iREN=0; redirect to 0x40 -> halted=0, buffer flushed, iaddr=0x40.
6. RST high for one cycle during WAIT at 0x30 with buffer holding 1 entry -> next cycle pc=PC_INIT, valid_out=0, halted=0, state RUN, iaddr=PC_INIT.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core front end: machine word, HALT opcode,
// fetch FSM states and the fetch buffer entry.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  localparam logic [5:0] HALT = 6'b111111;

  typedef enum logic [1:0] {RUN, WAIT, SQUASH, HALTED} fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc_4;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage boundary: instruction-memory handshake, redirect input and
// the head-of-buffer output toward the IF/ID register.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  ihit;
  word_t iload;
  logic  redirect;
  word_t redirect_pc;
  logic  ready_in;
  logic  valid_out;
  word_t instr_out;
  word_t pc_4_out;
  logic  halted;

  modport master (
    output iREN, iaddr, valid_out, instr_out, pc_4_out, halted,
    input  ihit, iload, redirect, redirect_pc, ready_in
  );

  modport slave (
    input  iREN, iaddr, valid_out, instr_out, pc_4_out, halted,
    output ihit, iload, redirect, redirect_pc, ready_in
  );
endinterface

// File: rtl/fetch_buffer.sv
// In-order circular buffer of fetched words; flush empties it in one cycle.
module fetch_buffer
  import cpu_types_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         enq,
  input  logic         deq,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [PW-1:0] hd, tl;
  logic [CW-1:0] cnt;
  fetch_entry_t  mem [BUF_DEPTH];

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
    end else begin
      if (enq) tl <= tl + PW'(1);
      if (deq) hd <= hd + PW'(1);
      cnt <= cnt + CW'(enq) - CW'(deq);
    end
  end

  // Storage needs no reset; stale slots are never visible past the count.
  always_ff @(posedge CLK) begin
    if (enq) mem[tl] <= din;
  end

  assign full  = (cnt == CW'(BUF_DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[hd];
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs the imem handshake, buffers fetched
// words for decode, and handles redirects (including mid-miss) and HALT.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0000_0000,
  parameter int    BUF_DEPTH = 2
) (
  input logic CLK,
  input logic RST,
  fetch_stage_if.master fif
);
  fetch_state_t state;
  word_t        pc, pending_pc, rpc;
  logic         iren, take, enq, deq, full, empty, is_halt;
  fetch_entry_t head, din;

  assign rpc     = {fif.redirect_pc[31:2], 2'b00};
  assign is_halt = (fif.iload[31:26] == HALT);

  always_comb begin
    iren = 1'b0;
    case (state)
      RUN:          iren = !full;
      WAIT, SQUASH: iren = 1'b1;
      default:      iren = 1'b0;
    endcase
  end

  // A returned word is kept only when it belongs to the current PC stream.
  assign take = iren && fif.ihit && (state == RUN || state == WAIT);
  assign enq  = take && !fif.redirect;
  assign deq  = fif.valid_out && fif.ready_in;
  assign din  = '{instr: fif.iload, pc_4: pc + 32'd4};

  fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .CLK   (CLK),
    .RST   (RST),
    .enq   (enq),
    .deq   (deq),
    .flush (fif.redirect),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign fif.iREN      = iren;
  assign fif.iaddr     = pc;
  assign fif.valid_out = !empty && !fif.redirect;
  assign fif.instr_out = head.instr;
  assign fif.pc_4_out  = head.pc_4;
  assign fif.halted    = (state == HALTED);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc         <= PC_INIT;
      pending_pc <= '0;
      state      <= RUN;
    end else if (fif.redirect) begin
      if (state == HALTED) begin
        pc    <= rpc;
        state <= RUN;
      end else if (iren && !fif.ihit) begin
        // Outstanding request must finish at its old address; park the target.
        pending_pc <= rpc;
        state      <= SQUASH;
      end else begin
        pc    <= rpc;
        state <= RUN;
      end
    end else begin
      case (state)
        RUN, WAIT: begin
          if (take) begin
            if (is_halt) state <= HALTED;
            else begin
              pc    <= pc + 32'd4;
              state <= RUN;
            end
          end else if (iren) begin
            state <= WAIT;
          end
        end
        SQUASH: begin
          if (fif.ihit) begin
            pc    <= pending_pc;
            state <= RUN;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// random traffic compared every cycle against a queue-based reference model.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  localparam int    DEPTH = 2;
  localparam word_t PCI   = 32'h0000_0000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fetch_stage_if fif();

  fetch_stage #(.PC_INIT(PCI), .BUF_DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .fif (fif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: PC, a few flags describing what the memory port is
  // doing, and a queue holding exactly what decode should see.
  word_t        m_pc, m_target;
  bit           m_halted, m_miss, m_discard;
  fetch_entry_t q[$];

  task automatic model_reset();
    m_pc = PCI; m_target = '0;
    m_halted = 0; m_miss = 0; m_discard = 0;
    q.delete();
  endtask

  function automatic bit exp_iren();
    if (m_halted) return 1'b0;
    if (m_miss || m_discard) return 1'b1;
    return (q.size() < DEPTH);
  endfunction

  function automatic bit exp_valid();
    return (q.size() > 0) && !fif.redirect;
  endfunction

  task automatic lit(input string nm, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit v;
    v = exp_valid();
    lit("iREN",      32'(fif.iREN),      32'(exp_iren()));
    lit("iaddr",     fif.iaddr,          m_pc);
    lit("valid_out", 32'(fif.valid_out), 32'(v));
    lit("halted",    32'(fif.halted),    32'(m_halted));
    if (v) begin
      lit("instr_out", fif.instr_out, q[0].instr);
      lit("pc_4_out",  fif.pc_4_out,  q[0].pc_4);
    end
  endtask

  task automatic drive(input logic rst, input logic r, input word_t rpc,
                       input logic h, input word_t ld, input logic rdy);
    @(negedge CLK);
    RST = rst; fif.redirect = r; fif.redirect_pc = rpc;
    fif.ihit = h; fif.iload = ld; fif.ready_in = rdy;
    #1 compare();
  endtask

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic step();
    bit ir, v;
    word_t tgt;
    @(posedge CLK);
    if (RST) begin model_reset(); return; end
    ir  = exp_iren();
    v   = exp_valid();
    tgt = fif.redirect_pc & 32'hFFFF_FFFC;
    if (v && fif.ready_in) void'(q.pop_front());
    if (fif.redirect) begin
      q.delete();
      if (m_halted) begin
        m_pc = tgt; m_halted = 0;
      end else if (ir && !fif.ihit) begin
        m_target = tgt; m_discard = 1; m_miss = 0;
      end else begin
        m_pc = tgt; m_discard = 0; m_miss = 0;
      end
    end else if (!m_halted) begin
      if (m_discard) begin
        if (fif.ihit) begin m_pc = m_target; m_discard = 0; end
      end else if (ir) begin
        if (fif.ihit) begin
          q.push_back('{instr: fif.iload, pc_4: m_pc + 32'd4});
          m_miss = 0;
          if (fif.iload[31:26] == 6'h3F) m_halted = 1;
          else m_pc = m_pc + 32'd4;
        end else m_miss = 1;
      end
    end
  endtask

  localparam word_t NOP = 32'h2000_0001;

  initial begin
    fif.redirect = 0; fif.redirect_pc = '0; fif.ihit = 0;
    fif.iload = '0; fif.ready_in = 0;
    repeat (2) @(posedge CLK);
    model_reset();

    // Straight-line fetch, then a 3-cycle miss at 8
    drive(0, 0, 0, 1, NOP, 1);
    lit("rst_iREN", 32'(fif.iREN), 1); lit("rst_iaddr", fif.iaddr, 0);
    lit("rst_valid", 32'(fif.valid_out), 0); lit("rst_halted", 32'(fif.halted), 0);
    step();
    drive(0, 0, 0, 1, NOP, 1); lit("p1_iaddr", fif.iaddr, 4); lit("p1_pc4", fif.pc_4_out, 4); step();
    drive(0, 0, 0, 0, NOP, 1); lit("p1_iaddr8", fif.iaddr, 8); lit("p1_pc4b", fif.pc_4_out, 8); step();
    repeat (2) begin drive(0, 0, 0, 0, NOP, 1); lit("miss_iaddr", fif.iaddr, 8); step(); end
    drive(0, 0, 0, 1, NOP, 1); lit("miss_iren", 32'(fif.iREN), 1); step();
    drive(0, 0, 0, 1, NOP, 1); lit("miss_pc4", fif.pc_4_out, 12); lit("miss_next", fif.iaddr, 12); step();

    // Redirect during a miss at 0x10
    drive(0, 1, 32'h100, 0, NOP, 1); lit("sq_valid0", 32'(fif.valid_out), 0); step();
    drive(0, 0, 0, 0, NOP, 1); lit("sq_iaddr", fif.iaddr, 32'h10); step();
    drive(0, 0, 0, 1, NOP, 1); lit("sq_iaddr2", fif.iaddr, 32'h10); step();
    drive(0, 0, 0, 1, NOP, 1); lit("sq_new", fif.iaddr, 32'h100); lit("sq_valid1", 32'(fif.valid_out), 0); step();
    drive(0, 0, 0, 0, NOP, 1); lit("sq_pc4", fif.pc_4_out, 32'h104); step();

    // Decode stall fills the buffer, then drains in order
    drive(0, 1, 32'h50, 1, NOP, 0); step();
    drive(0, 0, 0, 1, NOP, 0); step();
    drive(0, 0, 0, 1, NOP, 0); step();
    drive(0, 0, 0, 1, NOP, 0);
    lit("full_iREN", 32'(fif.iREN), 0); lit("full_iaddr", fif.iaddr, 32'h58); lit("full_pc4", fif.pc_4_out, 32'h54);
    step();
    drive(0, 0, 0, 1, NOP, 1); lit("drain_pc4a", fif.pc_4_out, 32'h54); step();
    drive(0, 0, 0, 1, NOP, 1); lit("drain_pc4b", fif.pc_4_out, 32'h58); lit("drain_iren", 32'(fif.iREN), 1); step();

    // HALT then redirect out of it
    drive(0, 1, 32'h22, 1, NOP, 1); step();
    drive(0, 0, 0, 1, 32'hFFFF_FFFF, 1); lit("h_iaddr", fif.iaddr, 32'h20); step();
    drive(0, 0, 0, 1, NOP, 1);
    lit("h_halted", 32'(fif.halted), 1); lit("h_iREN", 32'(fif.iREN), 0);
    lit("h_pc4", fif.pc_4_out, 32'h24); lit("h_instr", fif.instr_out, 32'hFFFF_FFFF);
    step();
    drive(0, 1, 32'h40, 0, NOP, 1); step();
    drive(0, 0, 0, 0, NOP, 1); lit("h_exit", 32'(fif.halted), 0); lit("h_iaddr40", fif.iaddr, 32'h40); step();

    // Reset mid-miss with one entry buffered
    drive(0, 1, 32'h2C, 1, NOP, 0); step();
    drive(0, 0, 0, 1, NOP, 0); step();
    drive(0, 0, 0, 0, NOP, 0); step();
    drive(1, 0, 0, 0, NOP, 0); lit("r_pre_iaddr", fif.iaddr, 32'h30); lit("r_pre_valid", 32'(fif.valid_out), 1); step();
    drive(0, 0, 0, 0, NOP, 1);
    lit("r_iaddr", fif.iaddr, PCI); lit("r_valid", 32'(fif.valid_out), 0); lit("r_iren", 32'(fif.iREN), 1);
    step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      word_t ld;
      ld = $urandom;
      if ($urandom_range(19) == 0) ld[31:26] = 6'h3F;
      drive(($urandom_range(499) == 0), ($urandom_range(15) == 0), $urandom,
            ($urandom_range(9) < 6), ld, ($urandom_range(9) < 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
